// File: rtl/xbox_xmem_responder.sv
// ---------------------------------------------------------------------------
// xbox_xmem_responder
//
// Responder side of the XBOX accelerator memory interface. Holds NUM_MEMS
// independent banks of 256-bit lines. Each bank serves the accelerator
// directly: byte-enabled writes and registered reads with one cycle of
// latency. A single-word SOC (APB-side) port shares the same banks. The SOC
// port only touches a bank in a cycle where the accelerator leaves that bank
// idle. Completed in-range SOC writes are reported on the
// trig_soc_xmem_wr / trig_soc_xmem_wr_addr pair.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   xlr_mem_addr[m]          line address for bank m
//   xlr_mem_wdata[m]         256-bit write line for bank m
//   xlr_mem_be[m]            per-byte write enable for bank m
//   xlr_mem_rd[m]            read strobe; the line appears one cycle later
//   xlr_mem_wr[m]            write strobe
//   xlr_mem_rdata[m]         registered read line; held until the next read
//   soc_req/we/addr/wdata    SOC request, held stable until soc_ack
//   soc_ack, soc_rdata       one-cycle completion and read word
//   soc_starved              pulses once when a request has been blocked
//                            SOC_MAX_WAIT cycles
//   trig_soc_xmem_wr(_addr)  pulse and address of a completed SOC write
// ---------------------------------------------------------------------------
module xbox_xmem_responder #(
    parameter int NUM_MEMS           = 2,
    parameter int LOG2_LINES_PER_MEM = 4,
    parameter int SOC_MAX_WAIT       = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr,
    input  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_wdata,
    input  logic [NUM_MEMS-1:0][31:0]                   xlr_mem_be,
    input  logic [NUM_MEMS-1:0]                         xlr_mem_rd,
    input  logic [NUM_MEMS-1:0]                         xlr_mem_wr,
    output logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_rdata,
    input  logic                                        soc_req,
    input  logic                                        soc_we,
    input  logic [18:0]                                 soc_addr,
    input  logic [31:0]                                 soc_wdata,
    output logic                                        soc_ack,
    output logic [31:0]                                 soc_rdata,
    output logic                                        soc_starved,
    output logic [18:0]                                 trig_soc_xmem_wr_addr,
    output logic                                        trig_soc_xmem_wr
);

    localparam int L        = LOG2_LINES_PER_MEM;
    localparam int LINES    = 1 << L;
    localparam int MW       = (NUM_MEMS > 1) ? $clog2(NUM_MEMS) : 1;
    localparam int BANK_LSB = 5 + L;
    localparam int TOP_LSB  = BANK_LSB + MW;
    localparam int CW       = $clog2(SOC_MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    // SOC request registers
    state_t          state_q;
    logic            soc_we_q;
    logic [18:0]     soc_addr_q;
    logic [31:0]     soc_wdata_q;
    logic [CW-1:0]   wait_cnt_q;
    logic [CW-1:0]   wait_cnt_d;
    logic            soc_ack_q;
    logic            soc_rd_valid_q;
    logic            soc_starved_q;
    logic            trig_q;
    logic [18:0]     trig_addr_q;

    // Decode of the latched SOC address
    logic [2:0]          soc_word;
    logic [L-1:0]        soc_line;
    logic [MW-1:0]       soc_bank;
    logic                soc_in_range;
    logic [NUM_MEMS-1:0] soc_bank_hit;
    logic                soc_bank_busy;
    logic                soc_fire;
    logic [31:0]         soc_bank_word [NUM_MEMS];
    logic [31:0]         soc_rdata_mux;

    assign soc_word = soc_addr_q[4:2];
    assign soc_line = soc_addr_q[5 +: L];
    assign soc_bank = soc_addr_q[BANK_LSB +: MW];

    // Any set bit above the bank field, or a bank index past the last bank,
    // makes the access a no-op that still gets acknowledged.
    assign soc_in_range = ((soc_addr_q >> TOP_LSB) == '0)
                       && (32'(soc_bank) < 32'(NUM_MEMS));

    // An out-of-range request hits no bank, so it is never blocked.
    assign soc_bank_busy = |(soc_bank_hit & (xlr_mem_rd | xlr_mem_wr));
    assign soc_fire      = (state_q == S_WAIT) && !soc_bank_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MEMS; gi++) begin : g_bank
            logic [255:0]    mem_q [LINES];
            logic [255:0]    wline;
            logic [7:0][31:0] rdata_q;
            logic [31:0]     soc_word_q;
            logic            soc_wr_en;
            logic            soc_rd_en;

            assign wline           = xlr_mem_wdata[gi];
            assign soc_bank_hit[gi] = soc_in_range && (32'(soc_bank) == 32'(gi));
            assign soc_wr_en       = soc_fire && soc_we_q && soc_bank_hit[gi];
            assign soc_rd_en       = soc_fire && !soc_we_q && soc_bank_hit[gi];

            // Write port. The SOC is only granted on cycles where the
            // accelerator leaves this bank alone, so the else-branch never
            // hides an accelerator write.
            always_ff @(posedge clk) begin
                if (xlr_mem_wr[gi]) begin
                    for (int b = 0; b < 32; b++) begin
                        if (xlr_mem_be[gi][b]) begin
                            mem_q[xlr_mem_addr[gi]][b*8 +: 8] <= wline[b*8 +: 8];
                        end
                    end
                end else if (soc_wr_en) begin
                    mem_q[soc_line][{soc_word, 5'b00000} +: 32] <= soc_wdata_q;
                end
            end

            // Accelerator read port. The read samples the array before any
            // same-edge write lands, which gives read-before-write.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                end else if (xlr_mem_rd[gi]) begin
                    rdata_q <= mem_q[xlr_mem_addr[gi]];
                end
            end

            // SOC read port. It uses its own capture register so that an
            // SOC read never disturbs the held accelerator read line.
            always_ff @(posedge clk) begin
                if (soc_rd_en) begin
                    soc_word_q <= mem_q[soc_line][{soc_word, 5'b00000} +: 32];
                end
            end

            assign xlr_mem_rdata[gi] = rdata_q;
            assign soc_bank_word[gi] = soc_word_q;
        end
    endgenerate

    // The wait counter saturates at SOC_MAX_WAIT, so the starved pulse can
    // fire only once per request.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (wait_cnt_q != CW'(SOC_MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            soc_we_q       <= 1'b0;
            soc_addr_q     <= '0;
            soc_wdata_q    <= '0;
            wait_cnt_q     <= '0;
            soc_ack_q      <= 1'b0;
            soc_rd_valid_q <= 1'b0;
            soc_starved_q  <= 1'b0;
            trig_q         <= 1'b0;
            trig_addr_q    <= '0;
        end else begin
            soc_ack_q     <= 1'b0;
            soc_starved_q <= 1'b0;
            trig_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (soc_req) begin
                        soc_we_q    <= soc_we;
                        soc_addr_q  <= soc_addr;
                        soc_wdata_q <= soc_wdata;
                        wait_cnt_q  <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (soc_fire) begin
                        state_q        <= S_ACK;
                        soc_ack_q      <= 1'b1;
                        soc_rd_valid_q <= !soc_we_q && soc_in_range;
                        if (soc_we_q && soc_in_range) begin
                            trig_q      <= 1'b1;
                            trig_addr_q <= soc_addr_q;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (wait_cnt_q == CW'(SOC_MAX_WAIT - 1)) begin
                            soc_starved_q <= 1'b1;
                        end
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Read word is forced to zero for writes and out-of-range reads, and
    // outside the ack cycle.
    always_comb begin
        soc_rdata_mux = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (soc_ack_q && soc_rd_valid_q && soc_bank_hit[m]) begin
                soc_rdata_mux = soc_bank_word[m];
            end
        end
    end

    assign soc_ack               = soc_ack_q;
    assign soc_rdata             = soc_rdata_mux;
    assign soc_starved           = soc_starved_q;
    assign trig_soc_xmem_wr      = trig_q;
    assign trig_soc_xmem_wr_addr = trig_addr_q;

endmodule

// File: tb/tb_xbox_xmem_responder.sv
module tb_xbox_xmem_responder;

    localparam int NM   = 2;
    localparam int L    = 4;
    localparam int MAXW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [NM-1:0][L-1:0]     xlr_mem_addr  = '0;
    logic [NM-1:0][7:0][31:0] xlr_mem_wdata = '0;
    logic [NM-1:0][31:0]      xlr_mem_be    = '0;
    logic [NM-1:0]            xlr_mem_rd    = '0;
    logic [NM-1:0]            xlr_mem_wr    = '0;
    logic [NM-1:0][7:0][31:0] xlr_mem_rdata;
    logic                     soc_req   = 1'b0;
    logic                     soc_we    = 1'b0;
    logic [18:0]              soc_addr  = '0;
    logic [31:0]              soc_wdata = '0;
    logic                     soc_ack;
    logic [31:0]              soc_rdata;
    logic                     soc_starved;
    logic [18:0]              trig_soc_xmem_wr_addr;
    logic                     trig_soc_xmem_wr;

    always #5 clk = ~clk;

    xbox_xmem_responder #(
        .NUM_MEMS           (NM),
        .LOG2_LINES_PER_MEM (L),
        .SOC_MAX_WAIT       (MAXW)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .xlr_mem_addr          (xlr_mem_addr),
        .xlr_mem_wdata         (xlr_mem_wdata),
        .xlr_mem_be            (xlr_mem_be),
        .xlr_mem_rd            (xlr_mem_rd),
        .xlr_mem_wr            (xlr_mem_wr),
        .xlr_mem_rdata         (xlr_mem_rdata),
        .soc_req               (soc_req),
        .soc_we                (soc_we),
        .soc_addr              (soc_addr),
        .soc_wdata             (soc_wdata),
        .soc_ack               (soc_ack),
        .soc_rdata             (soc_rdata),
        .soc_starved           (soc_starved),
        .trig_soc_xmem_wr_addr (trig_soc_xmem_wr_addr),
        .trig_soc_xmem_wr      (trig_soc_xmem_wr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain memory arrays plus a description of the SOC
    // request lifecycle (accepted -> waiting on a busy bank -> acked).
    // ------------------------------------------------------------------
    logic [255:0]             mdl [NM][16];
    logic [NM-1:0][7:0][31:0] e_rdata     = '0;
    logic                     e_ack       = 1'b0;
    logic                     e_starved   = 1'b0;
    logic                     e_trig      = 1'b0;
    logic [31:0]              e_soc_rdata = '0;
    logic [18:0]              e_trig_addr = '0;

    bit           m_busy = 0;
    bit           m_done = 0;
    int           m_blocked = 0;
    logic         m_we = 1'b0;
    logic [18:0]  m_addr = '0;
    logic [31:0]  m_wdata = '0;
    int           m_bk, m_ln, m_wd;
    bit           m_oor, m_free, m_soc_w;
    logic [255:0] m_wl;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            e_rdata   = '0;
            e_ack     = 1'b0;
            e_starved = 1'b0;
            e_trig    = 1'b0;
            e_soc_rdata = '0;
            m_busy    = 0;
            m_done    = 0;
            m_blocked = 0;
        end else begin
            e_ack       = 1'b0;
            e_starved   = 1'b0;
            e_trig      = 1'b0;
            e_soc_rdata = '0;
            m_soc_w     = 0;
            // reads see the contents before this edge's writes
            for (int m = 0; m < NM; m++)
                if (xlr_mem_rd[m]) e_rdata[m] = mdl[m][xlr_mem_addr[m]];
            if (m_done) begin
                m_busy = 0;
                m_done = 0;
            end else if (m_busy) begin
                m_bk  = int'(m_addr >> 9);
                m_ln  = int'(m_addr[8:5]);
                m_wd  = int'(m_addr[4:2]);
                m_oor = (m_bk >= NM);
                m_free = 1;
                if (!m_oor) m_free = !(xlr_mem_rd[m_bk] || xlr_mem_wr[m_bk]);
                if (m_free) begin
                    e_ack  = 1'b1;
                    m_done = 1;
                    if (m_we) begin
                        if (!m_oor) begin
                            m_soc_w     = 1;
                            e_trig      = 1'b1;
                            e_trig_addr = m_addr;
                        end
                    end else if (!m_oor) begin
                        e_soc_rdata = mdl[m_bk][m_ln][m_wd*32 +: 32];
                    end
                end else if (m_blocked < MAXW) begin
                    m_blocked++;
                    if (m_blocked == MAXW) e_starved = 1'b1;
                end
            end else if (soc_req) begin
                m_busy    = 1;
                m_we      = soc_we;
                m_addr    = soc_addr;
                m_wdata   = soc_wdata;
                m_blocked = 0;
            end
            for (int m = 0; m < NM; m++) begin
                if (xlr_mem_wr[m]) begin
                    m_wl = xlr_mem_wdata[m];
                    for (int b = 0; b < 32; b++)
                        if (xlr_mem_be[m][b]) mdl[m][xlr_mem_addr[m]][b*8 +: 8] = m_wl[b*8 +: 8];
                end
            end
            if (m_soc_w) mdl[m_bk][m_ln][m_wd*32 +: 32] = m_wdata;
        end
    end

    // Compare process: every falling edge, against the model.
    bit cmp_en = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("xlr_rdata0", xlr_mem_rdata[0], e_rdata[0]);
            check("xlr_rdata1", xlr_mem_rdata[1], e_rdata[1]);
            check("soc_ack", soc_ack, e_ack);
            check("soc_starved", soc_starved, e_starved);
            check("trig", trig_soc_xmem_wr, e_trig);
            if (e_ack) check("soc_rdata", soc_rdata, e_soc_rdata);
            if (e_trig) check("trig_addr", trig_soc_xmem_wr_addr, e_trig_addr);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic soc_access(input logic we, input logic [18:0] addr, input logic [31:0] wd,
                              output int lat, output logic [31:0] rd, output logic trig_seen);
        soc_req   = 1'b1;
        soc_we    = we;
        soc_addr  = addr;
        soc_wdata = wd;
        lat       = 0;
        do begin
            tick();
            lat++;
        end while (!soc_ack && lat < 50);
        check("soc_ack_seen", soc_ack, 1'b1);
        rd        = soc_rdata;
        trig_seen = trig_soc_xmem_wr;
        $display("soc %s addr=%h wdata=%h -> lat=%0d rdata=%h trig=%0b",
                 we ? "wr" : "rd", addr, wd, lat, rd, trig_seen);
        tick();
        soc_req = 1'b0;
    endtask

    int          lat;
    logic [31:0] rdv;
    logic        tseen;
    int          starve_cnt, starve_at, ack_at, ack_cnt;

    initial begin
        #2 rst_n = 1'b0;
        #1 cmp_en = 1;
        // reset state
        check("rst_rdata", xlr_mem_rdata, '0);
        check("rst_ack", soc_ack, 1'b0);
        check("rst_soc_rdata", soc_rdata, 32'h0);
        check("rst_starved", soc_starved, 1'b0);
        check("rst_trig", trig_soc_xmem_wr, 1'b0);
        check("rst_trig_addr", trig_soc_xmem_wr_addr, 19'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // zero every line of both banks
        for (int ln = 0; ln < 16; ln++) begin
            xlr_mem_wr    = 2'b11;
            xlr_mem_be    = {2{32'hFFFF_FFFF}};
            xlr_mem_wdata = '0;
            xlr_mem_addr  = {L'(ln), L'(ln)};
            tick();
        end
        xlr_mem_wr = '0;
        xlr_mem_be = '0;

        // byte-enabled write then read
        xlr_mem_wr[0] = 1'b1; xlr_mem_addr[0] = 4'd3; xlr_mem_be[0] = 32'h0000_000F;
        xlr_mem_wdata[0] = {8{32'h1111_1111}}; xlr_mem_wdata[0][0] = 32'hDEAD_BEEF;
        tick();
        xlr_mem_wr[0] = 1'b0; xlr_mem_rd[0] = 1'b1;
        tick();
        xlr_mem_rd[0] = 1'b0;
        $display("xlr b0 l3 word0=%h word1=%h", xlr_mem_rdata[0][0], xlr_mem_rdata[0][1]);
        check("t1_word0", xlr_mem_rdata[0][0], 32'hDEAD_BEEF);
        check("t1_word1", xlr_mem_rdata[0][1], 32'h0);

        // partial byte enable over a prefilled word
        xlr_mem_wr[0] = 1'b1; xlr_mem_be[0] = 32'h0000_000F; xlr_mem_wdata[0][0] = 32'hFFFF_FFFF;
        tick();
        xlr_mem_be[0] = 32'h0000_0003; xlr_mem_wdata[0][0] = 32'h0000_1234;
        tick();
        xlr_mem_wr[0] = 1'b0; xlr_mem_rd[0] = 1'b1;
        tick();
        xlr_mem_rd[0] = 1'b0;
        $display("xlr b0 l3 partial word0=%h", xlr_mem_rdata[0][0]);
        check("t2_word0", xlr_mem_rdata[0][0], 32'hFFFF_1234);

        // same-cycle rd+wr returns old data
        xlr_mem_rd[1] = 1'b1; xlr_mem_wr[1] = 1'b1; xlr_mem_addr[1] = 4'd5;
        xlr_mem_be[1] = 32'h0000_000F; xlr_mem_wdata[1] = '0; xlr_mem_wdata[1][0] = 32'hA5A5_A5A5;
        tick();
        xlr_mem_wr[1] = 1'b0;
        $display("xlr b1 l5 rd+wr word0=%h", xlr_mem_rdata[1][0]);
        check("t3_old", xlr_mem_rdata[1][0], 32'h0);
        tick();
        xlr_mem_rd[1] = 1'b0;
        $display("xlr b1 l5 reread word0=%h", xlr_mem_rdata[1][0]);
        check("t3_new", xlr_mem_rdata[1][0], 32'hA5A5_A5A5);

        // SOC write into bank0 line3 word1 with the accelerator idle
        soc_access(1'b1, 19'h64, 32'h1234_5678, lat, rdv, tseen);
        check("t4_lat", lat, 2);
        check("t4_trig", tseen, 1'b1);
        xlr_mem_rd[0] = 1'b1; xlr_mem_addr[0] = 4'd3;
        tick();
        xlr_mem_rd[0] = 1'b0;
        $display("xlr b0 l3 word0=%h word1=%h", xlr_mem_rdata[0][0], xlr_mem_rdata[0][1]);
        check("t4_word1", xlr_mem_rdata[0][1], 32'h1234_5678);
        check("t4_word0", xlr_mem_rdata[0][0], 32'hFFFF_1234);

        // SOC read of bank1 while the accelerator keeps it busy
        xlr_mem_wr[1] = 1'b1; xlr_mem_addr[1] = 4'd0; xlr_mem_be[1] = 32'h0000_000F;
        xlr_mem_wdata[1][0] = 32'hCAFE_F00D;
        tick();
        xlr_mem_wr[1] = 1'b0; xlr_mem_be[1] = '0;
        xlr_mem_rd[1] = 1'b1; xlr_mem_addr[1] = 4'd2;
        soc_req = 1'b1; soc_we = 1'b0; soc_addr = 19'h200;
        starve_cnt = 0; starve_at = 0; ack_at = 0; rdv = '0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 11) xlr_mem_rd[1] = 1'b0;
            tick();
            if (soc_starved) begin
                starve_cnt++;
                starve_at = k;
            end
            if (soc_ack && ack_at == 0) begin
                ack_at = k;
                rdv = soc_rdata;
            end
            if (ack_at != 0 && k == ack_at + 1) soc_req = 1'b0;
        end
        soc_req = 1'b0;
        $display("soc rd 200 blocked: starved_pulses=%0d at=%0d ack_at=%0d rdata=%h",
                 starve_cnt, starve_at, ack_at, rdv);
        check("t5_starve_cnt", starve_cnt, 1);
        check("t5_starve_at", starve_at, 9);
        check("t5_ack_at", ack_at, 11);
        check("t5_rdata", rdv, 32'hCAFE_F00D);

        // reset while waiting on a busy bank
        xlr_mem_rd[1] = 1'b1;
        soc_req = 1'b1; soc_we = 1'b0; soc_addr = 19'h200;
        tick();
        tick();
        rst_n = 1'b0;
        soc_req = 1'b0;
        xlr_mem_rd = '0;
        #1;
        $display("reset mid-wait: ack=%0b starved=%0b trig=%0b", soc_ack, soc_starved, trig_soc_xmem_wr);
        check("t6_rst_rdata", xlr_mem_rdata, '0);
        check("t6_rst_ack", soc_ack, 1'b0);
        check("t6_rst_trig_addr", trig_soc_xmem_wr_addr, 19'h0);
        tick();
        tick();
        rst_n = 1'b1;
        ack_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (soc_ack) ack_cnt++;
        end
        check("t6_no_ack", ack_cnt, 0);

        // out-of-range write: acked, no trigger, no bank change
        soc_access(1'b1, 19'h400, 32'hBADB_AD00, lat, rdv, tseen);
        check("t6_oor_lat", lat, 2);
        check("t6_oor_trig", tseen, 1'b0);
        xlr_mem_rd = 2'b11; xlr_mem_addr = '0;
        tick();
        xlr_mem_rd = '0;
        $display("xlr l0 b0 word0=%h b1 word0=%h", xlr_mem_rdata[0][0], xlr_mem_rdata[1][0]);
        check("t6_b0_l0", xlr_mem_rdata[0][0], 32'h0);
        check("t6_b1_l0", xlr_mem_rdata[1][0], 32'hCAFE_F00D);

        // SOC reads: in range and out of range
        soc_access(1'b0, 19'h64, 32'h0, lat, rdv, tseen);
        check("t7_rd64", rdv, 32'h1234_5678);
        check("t7_rd64_lat", lat, 2);
        soc_access(1'b0, 19'h400, 32'h0, lat, rdv, tseen);
        check("t7_oor_rd", rdv, 32'h0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
